decode_stage_hs: RTL and testbench

//  Parametrised MIPS32 integer decode stage with a valid/allowin handshake on both sides.

---
 rtl/decode_stage_hs.sv | 207 ++++++++++++++++++++
 tb/tb_decode_stage_hs.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hs.sv
// MIPS32 decode stage: decodes one instruction per cycle into registered EXE/MEM/WB controls.
// Latency 1 cycle; backpressure via valid/allowin, optional one-entry skid buffer absorbs one extra word.
module decode_stage_hs #(
   parameter int ADDR_W      = 32,
   parameter int LINK_OFFSET = 8,
   parameter bit HAS_SKID    = 1'b1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              fe_valid,
   input  logic [31:0]       fe_inst,
   input  logic [ADDR_W-1:0] fe_pc,
   output logic              de_allowin,
   input  logic              stall,
   input  logic              exe_allowin,
   output logic [4:0]        fe_rs_addr,
   output logic [4:0]        fe_rt_addr,
   output logic [4:0]        de_rs_addr,
   output logic [4:0]        de_rt_addr,
   input  logic [31:0]       de_rs_data,
   input  logic [31:0]       de_rt_data,
   output logic              de_is_b,
   output logic              de_is_j,
   output logic              de_is_jr,
   output logic [3:0]        de_b_type,
   output logic [15:0]       de_b_offset,
   output logic [25:0]       de_j_index,
   output logic              de_valid,
   output logic [ADDR_W-1:0] de_pc,
   output logic [3:0]        de_aluop,
   output logic [31:0]       de_alusrc1,
   output logic [31:0]       de_alusrc2,
   output logic              de_mem_en,
   output logic [3:0]        de_mem_wen,
   output logic [31:0]       de_mem_wdata,
   output logic              de_reg_en,
   output logic              de_mem_read,
   output logic [4:0]        de_reg_waddr,
   output logic              de_ri
);
   localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                          OP_SLT = 4'd4, OP_SLTU = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                          OP_SRA = 4'd9, OP_LUI = 4'd10, OP_XOR = 4'd11, OP_NOR = 4'd12;

   typedef struct packed {
      logic [31:0]       inst;
      logic [ADDR_W-1:0] pc;
   } fe_dat_t;

   fe_dat_t s_dat, src_dat;
   logic    s_valid, src_valid, load_r;

   assign src_valid = s_valid | fe_valid;
   assign src_dat   = s_valid ? s_dat : {fe_inst, fe_pc};
   assign load_r    = src_valid & ~stall & (~de_valid | exe_allowin) & ~flush;

   generate
      if (HAS_SKID) begin : g_skid
         logic fe_acc;
         assign fe_acc     = fe_valid & ~s_valid;
         assign de_allowin = ~s_valid;
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               s_valid <= 1'b0;
               s_dat   <= '0;
            end else if (flush) begin
               s_valid <= 1'b0;
            end else if (s_valid) begin
               if (load_r) s_valid <= 1'b0;
            end else if (fe_acc && !load_r) begin
               s_valid <= 1'b1;
               s_dat   <= {fe_inst, fe_pc};
            end
         end
      end else begin : g_noskid
         assign s_valid    = 1'b0;
         assign s_dat      = '0;
         assign de_allowin = ~stall & (~de_valid | exe_allowin);
      end
   endgenerate

   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sa;
   logic [31:0] sext, zext, pc_ext, link_off;
   assign op       = src_dat.inst[31:26];
   assign rs       = src_dat.inst[25:21];
   assign rt       = src_dat.inst[20:16];
   assign rd       = src_dat.inst[15:11];
   assign sa       = src_dat.inst[10:6];
   assign fn       = src_dat.inst[5:0];
   assign sext     = {{16{src_dat.inst[15]}}, src_dat.inst[15:0]};
   assign zext     = {16'd0, src_dat.inst[15:0]};
   assign pc_ext   = 32'(src_dat.pc);
   assign link_off = 32'(LINK_OFFSET);

   logic [3:0]  d_aluop, d_wen, d_btype;
   logic [31:0] d_src1, d_src2;
   logic [4:0]  d_waddr;
   logic        d_mem_en, d_reg_en, d_mem_read, d_ri, d_rs_rd, d_rt_rd, d_b, d_j, d_jr;

   always_comb begin
      d_aluop = OP_ADD;  d_src1 = de_rs_data;  d_src2 = de_rt_data;  d_waddr = rt;
      d_mem_en = 1'b0;   d_wen = 4'b0;         d_reg_en = 1'b0;      d_mem_read = 1'b0;
      d_ri = 1'b0;       d_rs_rd = 1'b0;       d_rt_rd = 1'b0;
      d_b = 1'b0;        d_j = 1'b0;           d_jr = 1'b0;          d_btype = 4'd0;
      case (op)
         6'h00: begin
            d_reg_en = 1'b1; d_waddr = rd; d_rs_rd = 1'b1; d_rt_rd = 1'b1;
            case (fn)
               6'h00: begin d_aluop = OP_SLL; d_src1 = {27'd0, sa}; d_rs_rd = 1'b0; end
               6'h02: begin d_aluop = OP_SRL; d_src1 = {27'd0, sa}; d_rs_rd = 1'b0; end
               6'h03: begin d_aluop = OP_SRA; d_src1 = {27'd0, sa}; d_rs_rd = 1'b0; end
               6'h04: d_aluop = OP_SLL;
               6'h06: d_aluop = OP_SRL;
               6'h07: d_aluop = OP_SRA;
               6'h08: begin d_jr = 1'b1; d_reg_en = 1'b0; d_rt_rd = 1'b0; end
               6'h09: begin d_jr = 1'b1; d_rt_rd = 1'b0; d_src1 = pc_ext; d_src2 = link_off; end
               6'h20, 6'h21: d_aluop = OP_ADD;
               6'h22, 6'h23: d_aluop = OP_SUB;
               6'h24: d_aluop = OP_AND;
               6'h25: d_aluop = OP_OR;
               6'h26: d_aluop = OP_XOR;
               6'h27: d_aluop = OP_NOR;
               6'h2A: d_aluop = OP_SLT;
               6'h2B: d_aluop = OP_SLTU;
               default: d_ri = 1'b1;
            endcase
         end
         6'h01: begin
            d_b = 1'b1; d_rs_rd = 1'b1;
            case (rt)
               5'h00: d_btype = 4'd5;
               5'h01: d_btype = 4'd2;
               5'h10, 5'h11: begin
                  d_btype = (rt == 5'h10) ? 4'd6 : 4'd7;
                  d_reg_en = 1'b1; d_waddr = 5'd31; d_src1 = pc_ext; d_src2 = link_off;
               end
               default: d_ri = 1'b1;
            endcase
         end
         6'h02: d_j = 1'b1;
         6'h03: begin d_j = 1'b1; d_reg_en = 1'b1; d_waddr = 5'd31; d_src1 = pc_ext; d_src2 = link_off; end
         6'h04: begin d_b = 1'b1; d_btype = 4'd1; d_rs_rd = 1'b1; d_rt_rd = 1'b1; end
         6'h05: begin d_b = 1'b1; d_btype = 4'd0; d_rs_rd = 1'b1; d_rt_rd = 1'b1; end
         6'h06: begin d_b = 1'b1; d_btype = 4'd4; d_rs_rd = 1'b1; end
         6'h07: begin d_b = 1'b1; d_btype = 4'd3; d_rs_rd = 1'b1; end
         6'h08, 6'h09: begin d_reg_en = 1'b1; d_rs_rd = 1'b1; d_src2 = sext; end
         6'h0A: begin d_aluop = OP_SLT;  d_reg_en = 1'b1; d_rs_rd = 1'b1; d_src2 = sext; end
         6'h0B: begin d_aluop = OP_SLTU; d_reg_en = 1'b1; d_rs_rd = 1'b1; d_src2 = sext; end
         6'h0C: begin d_aluop = OP_AND;  d_reg_en = 1'b1; d_rs_rd = 1'b1; d_src2 = zext; end
         6'h0D: begin d_aluop = OP_OR;   d_reg_en = 1'b1; d_rs_rd = 1'b1; d_src2 = zext; end
         6'h0E: begin d_aluop = OP_XOR;  d_reg_en = 1'b1; d_rs_rd = 1'b1; d_src2 = zext; end
         6'h0F: begin d_aluop = OP_LUI;  d_reg_en = 1'b1; d_src2 = sext; end
         6'h23: begin d_mem_en = 1'b1; d_mem_read = 1'b1; d_reg_en = 1'b1; d_rs_rd = 1'b1; d_src2 = sext; end
         6'h2B: begin d_mem_en = 1'b1; d_wen = 4'b1111; d_rs_rd = 1'b1; d_rt_rd = 1'b1; d_src2 = sext; end
         default: d_ri = 1'b1;
      endcase
      // A reserved word must leave no trace: no writes, no redirect, no hazard sources.
      if (d_ri) begin
         d_aluop = OP_ADD; d_reg_en = 1'b0; d_mem_en = 1'b0; d_wen = 4'b0; d_mem_read = 1'b0;
         d_b = 1'b0; d_j = 1'b0; d_jr = 1'b0; d_rs_rd = 1'b0; d_rt_rd = 1'b0;
      end
   end

   logic redir_ok;
   assign redir_ok    = src_valid & ~stall & ~flush;
   assign de_is_b     = redir_ok & d_b;
   assign de_is_j     = redir_ok & d_j;
   assign de_is_jr    = redir_ok & d_jr;
   assign de_b_type   = d_btype;
   assign de_b_offset = src_dat.inst[15:0];
   assign de_j_index  = src_dat.inst[25:0];
   assign fe_rs_addr  = rs;
   assign fe_rt_addr  = rt;
   assign de_rs_addr  = d_rs_rd ? rs : 5'd0;
   assign de_rt_addr  = d_rt_rd ? rt : 5'd0;

   logic       r_mem_en, r_reg_en, r_mem_read, r_ri;
   logic [3:0] r_mem_wen;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) de_valid <= 1'b0;
      else if (flush) de_valid <= 1'b0;
      else if (load_r) de_valid <= 1'b1;
      else if (exe_allowin) de_valid <= 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         de_pc <= '0; de_aluop <= '0; de_alusrc1 <= '0; de_alusrc2 <= '0; de_mem_wdata <= '0;
         de_reg_waddr <= '0; r_mem_en <= 1'b0; r_mem_wen <= '0; r_reg_en <= 1'b0;
         r_mem_read <= 1'b0; r_ri <= 1'b0;
      end else if (load_r) begin
         de_pc <= src_dat.pc; de_aluop <= d_aluop; de_alusrc1 <= d_src1; de_alusrc2 <= d_src2;
         de_mem_wdata <= de_rt_data; de_reg_waddr <= d_waddr; r_mem_en <= d_mem_en;
         r_mem_wen <= d_wen; r_reg_en <= d_reg_en; r_mem_read <= d_mem_read; r_ri <= d_ri;
      end
   end

   // Side-effect controls are masked so a bubble can never write.
   assign de_mem_en   = de_valid & r_mem_en;
   assign de_mem_wen  = de_valid ? r_mem_wen : 4'b0;
   assign de_reg_en   = de_valid & r_reg_en;
   assign de_mem_read = de_valid & r_mem_read;
   assign de_ri       = de_valid & r_ri;
endmodule

// File: tb/tb_decode_stage_hs.sv
// Scoreboard bench for decode_stage_hs (HAS_SKID=1): hand-derived expectations per instruction.
module tb_decode_stage_hs;
   localparam logic [31:0] RS_D = 32'd5;
   localparam logic [31:0] RT_D = 32'hA5A5_0001;

   logic        clk = 1'b0;
   logic        resetn, flush, fe_valid, stall, exe_allowin;
   logic [31:0] fe_inst, fe_pc, de_rs_data, de_rt_data;
   logic        de_allowin, de_is_b, de_is_j, de_is_jr, de_valid;
   logic [4:0]  fe_rs_addr, fe_rt_addr, de_rs_addr, de_rt_addr, de_reg_waddr;
   logic [3:0]  de_b_type, de_aluop, de_mem_wen;
   logic [15:0] de_b_offset;
   logic [25:0] de_j_index;
   logic [31:0] de_pc, de_alusrc1, de_alusrc2, de_mem_wdata;
   logic        de_mem_en, de_reg_en, de_mem_read, de_ri;

   always #5 clk = ~clk;

   decode_stage_hs dut (
      .clk(clk), .resetn(resetn), .flush(flush), .fe_valid(fe_valid), .fe_inst(fe_inst),
      .fe_pc(fe_pc), .de_allowin(de_allowin), .stall(stall), .exe_allowin(exe_allowin),
      .fe_rs_addr(fe_rs_addr), .fe_rt_addr(fe_rt_addr), .de_rs_addr(de_rs_addr),
      .de_rt_addr(de_rt_addr), .de_rs_data(de_rs_data), .de_rt_data(de_rt_data),
      .de_is_b(de_is_b), .de_is_j(de_is_j), .de_is_jr(de_is_jr), .de_b_type(de_b_type),
      .de_b_offset(de_b_offset), .de_j_index(de_j_index), .de_valid(de_valid), .de_pc(de_pc),
      .de_aluop(de_aluop), .de_alusrc1(de_alusrc1), .de_alusrc2(de_alusrc2),
      .de_mem_en(de_mem_en), .de_mem_wen(de_mem_wen), .de_mem_wdata(de_mem_wdata),
      .de_reg_en(de_reg_en), .de_mem_read(de_mem_read), .de_reg_waddr(de_reg_waddr), .de_ri(de_ri)
   );

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  aluop;
      logic [31:0] src1, src2;
      logic        mem_en;
      logic [3:0]  wen;
      logic        reg_en, mem_read;
      logic [4:0]  waddr;
      logic        ri;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sa, fn};
   endfunction

   function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] aluop,
                               input logic [31:0] s1, input logic [31:0] s2, input logic men,
                               input logic [3:0] wen, input logic ren, input logic mrd,
                               input logic [4:0] wa, input logic ri);
      exp_t e;
      e.pc = pc; e.aluop = aluop; e.src1 = s1; e.src2 = s2; e.mem_en = men; e.wen = wen;
      e.reg_en = ren; e.mem_read = mrd; e.waddr = wa; e.ri = ri;
      return e;
   endfunction

   // Instructions leave the stage when EXE takes them at the coming edge.
   always @(negedge clk) begin
      if (resetn && de_valid && exe_allowin && !flush) begin
         if (sb.size() == 0) begin
            chk_eq("sb_extra_output", de_pc, 32'hDEAD_BEEF);
         end else begin
            m_e = sb.pop_front();
            chk_eq("pc", de_pc, m_e.pc);
            chk_eq("aluop", 32'(de_aluop), 32'(m_e.aluop));
            chk_eq("ri", 32'(de_ri), 32'(m_e.ri));
            chk_eq("reg_en", 32'(de_reg_en), 32'(m_e.reg_en));
            chk_eq("mem_en", 32'(de_mem_en), 32'(m_e.mem_en));
            chk_eq("mem_wen", 32'(de_mem_wen), 32'(m_e.wen));
            if (!m_e.ri) begin
               chk_eq("src1", de_alusrc1, m_e.src1);
               chk_eq("src2", de_alusrc2, m_e.src2);
               chk_eq("mem_read", 32'(de_mem_read), 32'(m_e.mem_read));
               chk_eq("waddr", 32'(de_reg_waddr), 32'(m_e.waddr));
               chk_eq("wdata", de_mem_wdata, RT_D);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
      fe_valid = 1'b1; fe_inst = inst; fe_pc = pc;
      #1;
   endtask

   // Offers a word until the stage accepts it; returns 1ns after the accepting edge with fe idle.
   task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
      bit done = 1'b0;
      fe_valid = 1'b1; fe_inst = inst; fe_pc = pc;
      for (int k = 0; k < 50 && !done; k++) begin
         #1;
         if (de_allowin && !flush) begin
            sb.push_back(e);
            done = 1'b1;
         end
         tick();
      end
      fe_valid = 1'b0;
      if (!done) chk_eq("send_timeout", 32'd0, 32'd1);
   endtask

   logic [31:0] ins;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; flush = 1'b0; stall = 1'b0; exe_allowin = 1'b1;
      de_rs_data = RS_D; de_rt_data = RT_D;
      fe_valid = 1'b1; fe_inst = i_ins(6'h09, 5'd1, 5'd2, 16'hFFFF); fe_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_de_valid", 32'(de_valid), 32'd0);
      chk_eq("rst_reg_en", 32'(de_reg_en), 32'd0);
      chk_eq("rst_mem_wen", 32'(de_mem_wen), 32'd0);
      chk_eq("rst_allowin", 32'(de_allowin), 32'd1);
      fe_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // ADDIU $2,$1,-1
      ins = i_ins(6'h09, 5'd1, 5'd2, 16'hFFFF);
      drive(ins, 32'h0);
      chk_eq("addiu_fe_rs", 32'(fe_rs_addr), 32'd1);
      chk_eq("addiu_de_rs", 32'(de_rs_addr), 32'd1);
      chk_eq("addiu_de_rt", 32'(de_rt_addr), 32'd0);
      send(ins, 32'h0, mk(32'h0, 4'd2, RS_D, 32'hFFFF_FFFF, 1'b0, 4'h0, 1'b1, 1'b0, 5'd2, 1'b0));
      chk_eq("addiu_latency", 32'(de_valid), 32'd1);

      // JAL at 0x100
      ins = i_ins(6'h03, 5'd0, 5'd0, 16'h0040);
      drive(ins, 32'h100);
      chk_eq("jal_is_j", 32'(de_is_j), 32'd1);
      chk_eq("jal_is_b", 32'(de_is_b), 32'd0);
      chk_eq("jal_index", 32'(de_j_index), 32'h40);
      send(ins, 32'h100, mk(32'h100, 4'd2, 32'h100, 32'd8, 1'b0, 4'h0, 1'b1, 1'b0, 5'd31, 1'b0));

      send(i_ins(6'h0D, 5'd1, 5'd3, 16'h8001), 32'h104,
           mk(32'h104, 4'd1, RS_D, 32'h8001, 1'b0, 4'h0, 1'b1, 1'b0, 5'd3, 1'b0));
      send(r_ins(5'd0, 5'd2, 5'd4, 5'd3, 6'h00), 32'h108,
           mk(32'h108, 4'd6, 32'd3, RT_D, 1'b0, 4'h0, 1'b1, 1'b0, 5'd4, 1'b0));
      send(r_ins(5'd1, 5'd2, 5'd5, 5'd0, 6'h23), 32'h10C,
           mk(32'h10C, 4'd3, RS_D, RT_D, 1'b0, 4'h0, 1'b1, 1'b0, 5'd5, 1'b0));
      send(i_ins(6'h23, 5'd1, 5'd6, 16'hFFFC), 32'h110,
           mk(32'h110, 4'd2, RS_D, 32'hFFFF_FFFC, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 1'b0));

      // BGEZAL $1
      ins = i_ins(6'h01, 5'd1, 5'h11, 16'h0004);
      drive(ins, 32'h114);
      chk_eq("bgezal_is_b", 32'(de_is_b), 32'd1);
      chk_eq("bgezal_type", 32'(de_b_type), 32'd7);
      chk_eq("bgezal_off", 32'(de_b_offset), 32'd4);
      send(ins, 32'h114, mk(32'h114, 4'd2, 32'h114, 32'd8, 1'b0, 4'h0, 1'b1, 1'b0, 5'd31, 1'b0));
      send(i_ins(6'h0F, 5'd0, 5'd7, 16'h1234), 32'h118,
           mk(32'h118, 4'd10, RS_D, 32'h1234, 1'b0, 4'h0, 1'b1, 1'b0, 5'd7, 1'b0));
      send(r_ins(5'd1, 5'd2, 5'd8, 5'd0, 6'h07), 32'h11C,
           mk(32'h11C, 4'd9, RS_D, RT_D, 1'b0, 4'h0, 1'b1, 1'b0, 5'd8, 1'b0));
      repeat (3) tick();

      // EXE blocked for three cycles while fetch streams three words
      fork
         begin
            send(r_ins(5'd1, 5'd2, 5'd9, 5'd0, 6'h26), 32'h200,
                 mk(32'h200, 4'd11, RS_D, RT_D, 1'b0, 4'h0, 1'b1, 1'b0, 5'd9, 1'b0));
            send(i_ins(6'h0B, 5'd1, 5'd10, 16'h8000), 32'h204,
                 mk(32'h204, 4'd5, RS_D, 32'hFFFF_8000, 1'b0, 4'h0, 1'b1, 1'b0, 5'd10, 1'b0));
            chk_eq("skid_allowin_low", 32'(de_allowin), 32'd0);
            send(r_ins(5'd1, 5'd2, 5'd11, 5'd0, 6'h27), 32'h208,
                 mk(32'h208, 4'd12, RS_D, RT_D, 1'b0, 4'h0, 1'b1, 1'b0, 5'd11, 1'b0));
         end
         begin
            exe_allowin = 1'b0;
            repeat (3) tick();
            exe_allowin = 1'b1;
         end
      join
      repeat (3) tick();

      // One-cycle load-use stall ahead of a store
      send(i_ins(6'h0C, 5'd1, 5'd12, 16'hF0F0), 32'h300,
           mk(32'h300, 4'd0, RS_D, 32'hF0F0, 1'b0, 4'h0, 1'b1, 1'b0, 5'd12, 1'b0));
      stall = 1'b1;
      send(i_ins(6'h2B, 5'd1, 5'd2, 16'h0008), 32'h304,
           mk(32'h304, 4'd2, RS_D, 32'd8, 1'b1, 4'hF, 1'b0, 1'b0, 5'd2, 1'b0));
      stall = 1'b0;
      chk_eq("bubble_valid", 32'(de_valid), 32'd0);
      chk_eq("bubble_wen", 32'(de_mem_wen), 32'd0);
      chk_eq("bubble_held", 32'(de_allowin), 32'd0);
      repeat (3) tick();

      // Flush with both the output register and the skid entry occupied
      exe_allowin = 1'b0;
      send(i_ins(6'h09, 5'd1, 5'd2, 16'h0001), 32'h400,
           mk(32'h400, 4'd2, RS_D, 32'd1, 1'b0, 4'h0, 1'b1, 1'b0, 5'd2, 1'b0));
      send(i_ins(6'h05, 5'd1, 5'd2, 16'h0010), 32'h404,
           mk(32'h404, 4'd2, RS_D, RT_D, 1'b0, 4'h0, 1'b0, 1'b0, 5'd2, 1'b0));
      #1;
      chk_eq("bne_is_b", 32'(de_is_b), 32'd1);
      chk_eq("bne_type", 32'(de_b_type), 32'd0);
      flush = 1'b1;
      fe_valid = 1'b1; fe_inst = i_ins(6'h09, 5'd3, 5'd4, 16'h0002); fe_pc = 32'h408;
      #1;
      chk_eq("flush_no_redirect", 32'(de_is_b), 32'd0);
      tick();
      flush = 1'b0; fe_valid = 1'b0;
      chk_eq("flush_de_valid", 32'(de_valid), 32'd0);
      chk_eq("flush_s_empty", 32'(de_allowin), 32'd1);
      sb.delete();
      exe_allowin = 1'b1;

      ins = 32'hFC00_0000;
      drive(ins, 32'h40C);
      chk_eq("ri_no_j", 32'({de_is_b, de_is_j, de_is_jr}), 32'd0);
      send(ins, 32'h40C, mk(32'h40C, 4'd2, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b1));
      #1;
      chk_eq("ri_flag", 32'(de_ri), 32'd1);
      chk_eq("ri_reg_en", 32'(de_reg_en), 32'd0);
      repeat (3) tick();

      // Asynchronous reset while an instruction is held
      exe_allowin = 1'b0;
      send(i_ins(6'h09, 5'd1, 5'd2, 16'h0003), 32'h500,
           mk(32'h500, 4'd2, RS_D, 32'd3, 1'b0, 4'h0, 1'b1, 1'b0, 5'd2, 1'b0));
      #2;
      resetn = 1'b0;
      #1;
      chk_eq("arst_de_valid", 32'(de_valid), 32'd0);
      chk_eq("arst_allowin", 32'(de_allowin), 32'd1);
      sb.delete();
      @(negedge clk);
      resetn = 1'b1;
      exe_allowin = 1'b1;
      tick();

      send(i_ins(6'h0E, 5'd1, 5'd13, 16'h00FF), 32'h600,
           mk(32'h600, 4'd11, RS_D, 32'h00FF, 1'b0, 4'h0, 1'b1, 1'b0, 5'd13, 1'b0));
      repeat (5) tick();
      chk_eq("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
